regfile_multiport: RTL and testbench

//  Parametrised register file for the multi-cycle CPU datapath: NUM_RD registered read ports, one write port.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_multiport_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_multiport.sv | 106 ++++++++++
 tb/tb_regfile_multiport.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Holds the default geometry and the zero constant used for unmapped reads.
package regfile_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_NUM_RD   = 2;

  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam reg_data_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport: read ports, write port, scoreboard set and debug views.
// The master side issues accesses; the slave side is the register file.
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD
) ();

  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       busy_set;
  logic [ADDR_W-1:0]          busy_addr;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [NUM_REGS-1:0]        busy_vec;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
    input  rd_data, rd_busy, regs_flat, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
    output rd_data, rd_busy, regs_flat, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per implemented register.
// A set and a clear on the same register in one cycle leaves it busy (new producer issued).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter bit R0_ZERO  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_set,
  input  logic [ADDR_W-1:0]   i_set_addr,
  input  logic                i_clr,
  input  logic [ADDR_W-1:0]   i_clr_addr,
  output logic [NUM_REGS-1:0] o_busy_vec
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_hit;
  logic [NUM_REGS-1:0] w_clr_hit;

  // NOTE: every bit is assigned a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    w_set_hit = '0;
    w_clr_hit = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_set_hit[k] = i_set && (i_set_addr == ADDR_W'(k)) && !(R0_ZERO && k == 0);
      w_clr_hit[k] = i_clr && (i_clr_addr == ADDR_W'(k));
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_set_hit[k])      r_busy[k] <= 1'b1;
        else if (w_clr_hit[k]) r_busy[k] <= 1'b0;
      end
    end
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file with registered reads, one write port and a RAW scoreboard.
// Define REGFILE_BYPASS_EN for write-first forwarding; default is read-first.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter bit R0_ZERO  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  regfile_multiport_if.slave io_bus
);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NUM_RD-1:0][DATA_W-1:0]   r_rd_data;
  logic [NUM_RD-1:0]               r_rd_busy;

  logic [NUM_RD-1:0][ADDR_W-1:0]   w_rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]   w_rd_data;
  logic [NUM_RD-1:0]               w_rd_busy;
  logic [NUM_REGS-1:0]             w_wr_hit;
  logic [NUM_REGS-1:0]             w_busy_vec;

  assign w_rd_addr = io_bus.rd_addr;

  // A write only lands on an implemented register that is not a hardwired zero.
  always_comb begin
    w_wr_hit = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_wr_hit[k] = io_bus.wr_en && (io_bus.wr_addr == ADDR_W'(k)) && !(R0_ZERO && k == 0);
    end
  end

  // NOTE: the storage array is reset on purpose: the debug view and reads must be zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regs <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_wr_hit[k]) r_regs[k] <= io_bus.wr_data;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .R0_ZERO  (R0_ZERO)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (reset),
    .i_set      (io_bus.busy_set),
    .i_set_addr (io_bus.busy_addr),
    .i_clr      (io_bus.wr_en),
    .i_clr_addr (io_bus.wr_addr),
    .o_busy_vec (w_busy_vec)
  );

  // Unmapped addresses fall through the loop and keep the zero defaults.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_data[i] = DATA_W'(REG_ZERO);
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_rd_addr[i] == ADDR_W'(k)) begin
`ifdef REGFILE_BYPASS_EN
          if (w_wr_hit[k]) begin
            w_rd_data[i] = io_bus.wr_data;
            w_rd_busy[i] = io_bus.busy_set && (io_bus.busy_addr == w_rd_addr[i]);
          end else begin
            w_rd_data[i] = r_regs[k];
            w_rd_busy[i] = w_busy_vec[k];
          end
`else
          w_rd_data[i] = r_regs[k];
          w_rd_busy[i] = w_busy_vec[k];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (io_bus.rd_en[i]) begin
          r_rd_data[i] <= w_rd_data[i];
          r_rd_busy[i] <= w_rd_busy[i];
        end
      end
    end
  end

  assign io_bus.rd_data   = r_rd_data;
  assign io_bus.rd_busy   = r_rd_busy;
  assign io_bus.regs_flat = r_regs;
  assign io_bus.busy_vec  = w_busy_vec;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: two configurations (4 regs plain, 3 regs with zero r0) on one stimulus.
// A behavioural model is compared every cycle; directed cases pin the model with literal values.
module tb_regfile_multiport;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  s_rd_en;
  logic [3:0]  s_rd_addr;
  logic        s_wr_en;
  logic [1:0]  s_wr_addr;
  reg_data_t   s_wr_data;
  logic        s_busy_set;
  logic [1:0]  s_busy_addr;

  regfile_multiport_if #(.NUM_REGS(4)) if0 ();
  regfile_multiport_if #(.NUM_REGS(3)) if1 ();

  assign if0.rd_en = s_rd_en;     assign if1.rd_en = s_rd_en;
  assign if0.rd_addr = s_rd_addr; assign if1.rd_addr = s_rd_addr;
  assign if0.wr_en = s_wr_en;     assign if1.wr_en = s_wr_en;
  assign if0.wr_addr = s_wr_addr; assign if1.wr_addr = s_wr_addr;
  assign if0.wr_data = s_wr_data; assign if1.wr_data = s_wr_data;
  assign if0.busy_set = s_busy_set;   assign if1.busy_set = s_busy_set;
  assign if0.busy_addr = s_busy_addr; assign if1.busy_addr = s_busy_addr;

  regfile_multiport #(.NUM_REGS(4), .R0_ZERO(1'b0)) u_dut0 (.clk(clk), .reset(reset), .io_bus(if0));
  regfile_multiport #(.NUM_REGS(3), .R0_ZERO(1'b1)) u_dut1 (.clk(clk), .reset(reset), .io_bus(if1));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_regs [2][4];
  logic [3:0]  m_busy [2];
  logic [15:0] m_rd   [2][2];
  logic [1:0]  m_rdb  [2];

  function automatic int nregs(input int c);
    return (c == 0) ? 4 : 3;
  endfunction

  function automatic bit writable(input int c, input int a);
    return (a < nregs(c)) && !(c == 1 && a == 0);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) m_regs[c][k] = 16'h0;
      m_busy[c] = 4'h0;
      m_rd[c][0] = 16'h0;
      m_rd[c][1] = 16'h0;
      m_rdb[c] = 2'b00;
    end
  endtask

  task automatic model_step();
    int wa, ba, ra;
    wa = int'(s_wr_addr);
    ba = int'(s_busy_addr);
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (s_rd_en[i]) begin
          ra = int'(s_rd_addr[i*2 +: 2]);
          if (ra >= nregs(c)) begin
            m_rd[c][i] = 16'h0;
            m_rdb[c][i] = 1'b0;
          end
`ifdef REGFILE_BYPASS_EN
          else if (s_wr_en && wa == ra && writable(c, ra)) begin
            m_rd[c][i] = s_wr_data;
            m_rdb[c][i] = s_busy_set && (ba == ra);
          end
`endif
          else begin
            m_rd[c][i] = m_regs[c][ra];
            m_rdb[c][i] = m_busy[c][ra];
          end
        end
      end
      if (s_wr_en && writable(c, wa)) m_regs[c][wa] = s_wr_data;
      if (s_wr_en && wa < nregs(c)) m_busy[c][wa] = 1'b0;
      if (s_busy_set && writable(c, ba)) m_busy[c][ba] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    if (reset) model_clear();
    else       model_step();
  end

  // ---------------- per-cycle compare ----------------
  logic [63:0] a_regs [2];
  logic [3:0]  a_busy [2];
  logic [31:0] a_rd   [2];
  logic [1:0]  a_rdb  [2];

  always_comb begin
    a_regs[0] = if0.regs_flat;
    a_regs[1] = {16'h0, if1.regs_flat};
    a_busy[0] = if0.busy_vec;
    a_busy[1] = {1'b0, if1.busy_vec};
    a_rd[0]   = if0.rd_data;
    a_rd[1]   = if1.rd_data;
    a_rdb[0]  = if0.rd_busy;
    a_rdb[1]  = if1.rd_busy;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        logic [63:0] e_regs;
        e_regs = 64'h0;
        for (int k = 0; k < nregs(c); k++) e_regs[k*16 +: 16] = m_regs[c][k];
        check($sformatf("dut%0d regs_flat", c), a_regs[c], e_regs);
        check($sformatf("dut%0d busy_vec", c), 64'(a_busy[c]), 64'(m_busy[c]));
        check($sformatf("dut%0d rd_data", c), 64'(a_rd[c]), 64'({m_rd[c][1], m_rd[c][0]}));
        check($sformatf("dut%0d rd_busy", c), 64'(a_rdb[c]), 64'(m_rdb[c]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    s_rd_en = 2'b00;
    s_rd_addr = 4'h0;
    s_wr_en = 1'b0;
    s_wr_addr = 2'd0;
    s_wr_data = 16'h0;
    s_busy_set = 1'b0;
    s_busy_addr = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input reg_data_t d);
    s_wr_en = 1'b1;
    s_wr_addr = a;
    s_wr_data = d;
  endtask

  // Reset pulse between edges; the model is cleared at the same instant.
  task automatic pulse_reset();
    reset = 1'b1;
    model_clear();
    #1;
    reset = 1'b0;
  endtask

  logic [15:0] exp_same_edge;

  initial begin
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset regs0", if0.regs_flat, 64'h0);
    check("reset busy1", 64'(if1.busy_vec), 64'h0);

    // 1: write BEEF to r2, mark r1 busy, read r1, then reset mid-cycle
    idle(); write(2'd2, 16'hBEEF); s_busy_set = 1'b1; s_busy_addr = 2'd1;
    tick();
    check("t1 r2 beef", 64'(if0.regs_flat[47:32]), 64'hBEEF);
    idle(); s_rd_en = 2'b10; s_rd_addr = 4'b0100;
    tick();
    check("t1 rd_busy before reset", 64'(if0.rd_busy), 64'h2);
    reset = 1'b1;
    model_clear();
    #1;
    check("t1 async regs0", if0.regs_flat, 64'h0);
    check("t1 async regs1", 64'(if1.regs_flat), 64'h0);
    check("t1 async rd_data0", 64'(if0.rd_data), 64'h0);
    check("t1 async rd_busy0", 64'(if0.rd_busy), 64'h0);
    check("t1 async busy_vec0", 64'(if0.busy_vec), 64'h0);
    reset = 1'b0;

    // 2: write r1, read it on both ports, then hold with rd_en low
    idle(); write(2'd1, 16'h1234);
    tick();
    idle(); s_rd_en = 2'b11; s_rd_addr = 4'b0101;
    tick();
    check("t2 dual read dut0", 64'(if0.rd_data), 64'h12341234);
    check("t2 dual read dut1", 64'(if1.rd_data), 64'h12341234);
    idle(); write(2'd1, 16'h5555);
    tick();
    idle();
    tick();
    check("t2 hold dut0", 64'(if0.rd_data), 64'h12341234);

    // 3: same-edge read and write of r3
    idle(); write(2'd3, 16'h0055);
    tick();
    idle(); write(2'd3, 16'h00AA); s_rd_en = 2'b01; s_rd_addr = 4'b0011;
    tick();
`ifdef REGFILE_BYPASS_EN
    exp_same_edge = 16'h00AA;
`else
    exp_same_edge = 16'h0055;
`endif
    check("t3 same edge dut0", 64'(if0.rd_data[15:0]), 64'(exp_same_edge));
    check("t3 unmapped dut1", 64'(if1.rd_data[15:0]), 64'h0);

    // 4: scoreboard set, clear, and set-wins
    idle(); s_busy_set = 1'b1; s_busy_addr = 2'd2;
    tick();
    idle(); s_rd_en = 2'b01; s_rd_addr = 4'b0010;
    tick();
    check("t4 rd_busy dut0", 64'(if0.rd_busy[0]), 64'h1);
    check("t4 rd_busy dut1", 64'(if1.rd_busy[0]), 64'h1);
    idle(); write(2'd2, 16'h2222);
    tick();
    check("t4 clear dut0", 64'(if0.busy_vec[2]), 64'h0);
    idle(); write(2'd2, 16'h3333); s_busy_set = 1'b1; s_busy_addr = 2'd2;
    tick();
    check("t4 set wins dut0", 64'(if0.busy_vec[2]), 64'h1);
    check("t4 set wins dut1", 64'(if1.busy_vec[2]), 64'h1);

    // 5: zero r0 on dut1, ordinary r0 on dut0
    idle(); write(2'd0, 16'hFFFF); s_busy_set = 1'b1; s_busy_addr = 2'd0;
    tick();
    idle(); s_rd_en = 2'b01; s_rd_addr = 4'b0000;
    tick();
    check("t5 r0 read dut1", 64'(if1.rd_data[15:0]), 64'h0);
    check("t5 r0 busy dut1", 64'(if1.busy_vec[0]), 64'h0);
    check("t5 r0 read dut0", 64'(if0.rd_data[15:0]), 64'hFFFF);
    check("t5 r0 busy dut0", 64'(if0.busy_vec[0]), 64'h1);

    // 6: address 3 is unmapped on dut1
    pulse_reset();
    idle(); write(2'd3, 16'h7777); s_busy_set = 1'b1; s_busy_addr = 2'd3;
    tick();
    check("t6 regs unchanged dut1", 64'(if1.regs_flat), 64'h0);
    check("t6 busy unchanged dut1", 64'(if1.busy_vec), 64'h0);
    check("t6 r3 written dut0", 64'(if0.regs_flat[63:48]), 64'h7777);
    idle(); s_rd_en = 2'b11; s_rd_addr = 4'b1111;
    tick();
    check("t6 unmapped data dut1", 64'(if1.rd_data), 64'h0);
    check("t6 unmapped busy dut1", 64'(if1.rd_busy), 64'h0);
    check("t6 busy read dut0", 64'(if0.rd_busy), 64'h3);

    // randomized traffic, with occasional mid-cycle resets
    for (int n = 0; n < 2000; n++) begin
      s_rd_en     = 2'($urandom);
      s_rd_addr   = 4'($urandom);
      s_wr_en     = ($urandom_range(0, 2) != 0);
      s_wr_addr   = 2'($urandom);
      s_wr_data   = 16'($urandom);
      s_busy_set  = ($urandom_range(0, 2) == 0);
      s_busy_addr = ($urandom_range(0, 3) == 0) ? s_wr_addr : 2'($urandom);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      tick();
    end

    idle();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
